// File: rtl/pcma_coe_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pcma_coe_loader_if
// Brief   : Host and compensator-facing signals of the coefficient loader.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pcma_coe_loader_if #(
  parameter int COE_WIDTH  = 26,
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [COE_WIDTH-1:0]  wr_data;
  logic                  start;
  logic                  preset_en;
  logic                  o_preset_coe;
  logic                  o_load_coe;
  logic [COE_WIDTH-1:0]  o_init_coe;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, start, preset_en,
    input  o_preset_coe, o_load_coe, o_init_coe, o_busy, o_done, o_wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, preset_en,
    output o_preset_coe, o_load_coe, o_init_coe, o_busy, o_done, o_wr_err
  );
endinterface
`default_nettype wire

// File: rtl/pcma_coe_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pcma_coe_loader
// Brief   : Shadow tap bank plus sequencer that presets the compensator and
//           streams EQ_LEN taps with one load strobe per tap.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pcma_coe_loader #(
  parameter int COE_WIDTH  = 26,
  parameter int EQ_LEN     = 19,
  parameter int ADDR_WIDTH = 5,
  parameter int STROBE_GAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  pcma_coe_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESET = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [3:0]            c_gap      = 4'(STROBE_GAP);
  localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(EQ_LEN - 1);
  localparam logic [ADDR_WIDTH:0]   c_eq_len   = (ADDR_WIDTH + 1)'(EQ_LEN);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_idx_next;
  logic [3:0]            r_gap_cnt;
  logic [3:0]            w_gap_cnt_next;
  logic [COE_WIDTH-1:0]  r_bank [EQ_LEN];
  logic [COE_WIDTH-1:0]  r_init_coe;
  logic                  r_wr_err;

  logic w_start_acc;
  logic w_last;
  logic w_wr_acc;

  assign w_start_acc = (r_state == S_IDLE) && bus.start;
  assign w_last      = (r_idx == c_last_idx);

  // The bank is frozen from the cycle a start is accepted until IDLE returns.
  assign w_wr_acc = bus.wr_en && ({1'b0, bus.wr_addr} < c_eq_len)
                    && (r_state == S_IDLE) && !bus.start;

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_gap_cnt_next = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_idx_next   = '0;
          w_state_next = bus.preset_en ? S_PRESET : S_SETUP;
        end
      end
      S_PRESET: w_state_next = S_SETUP;
      S_SETUP:  w_state_next = S_STROBE;
      S_STROBE: begin
        if (c_gap == 4'd0) begin
          if (w_last) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_state_next = S_SETUP;
          end
        end else begin
          w_gap_cnt_next = c_gap - 4'd1;
          w_state_next   = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt != 4'd0) begin
          w_gap_cnt_next = r_gap_cnt - 4'd1;
        end else if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_idx_next   = r_idx + 1'b1;
          w_state_next = S_SETUP;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_gap_cnt  <= '0;
      r_init_coe <= '0;
      r_wr_err   <= 1'b0;
      for (int i = 0; i < EQ_LEN; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_gap_cnt <= w_gap_cnt_next;
      r_wr_err  <= bus.wr_en && !w_wr_acc;
      if (w_wr_acc) begin
        r_bank[bus.wr_addr] <= bus.wr_data;
      end
      // Data is presented one cycle ahead of the strobe and held through it.
      if (w_state_next == S_SETUP) begin
        r_init_coe <= r_bank[w_idx_next];
      end
    end
  end

  assign bus.o_preset_coe = (r_state == S_PRESET);
  assign bus.o_load_coe   = (r_state == S_STROBE);
  assign bus.o_done       = (r_state == S_DONE);
  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_init_coe   = r_init_coe;
  assign bus.o_wr_err     = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_pcma_coe_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_pcma_coe_loader
// Brief   : Scoreboard bench for pcma_coe_loader, two gap settings in parallel.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pcma_coe_loader;
  localparam int COE_WIDTH  = 26;
  localparam int EQ_LEN     = 19;
  localparam int ADDR_WIDTH = 5;
  localparam int K_PRE      = 0;
  localparam int K_LOAD     = 1;
  localparam int K_DONE     = 2;

  typedef struct {
    int                   kind;
    int                   cyc;
    logic [COE_WIDTH-1:0] val;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  wr_en = 1'b0;
  logic [ADDR_WIDTH-1:0] wr_addr = '0;
  logic [COE_WIDTH-1:0]  wr_data = '0;
  logic                  start = 1'b0;
  logic                  preset_en = 1'b0;
  int                    cyc = 0;
  bit                    mon_en = 1'b0;
  int                    n_pass = 0;
  int                    n_total = 0;

  int taps [EQ_LEN] = '{-3881, 1, -28991, 1, 119608, 1, -340650, -1, 1297264,
                        2097151, 1297264, -1, -340650, 1, 119608, 1, -28991, 1, -3881};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: actual %0d required %0d", nm, cyc, act, req);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int GAP = (g == 0) ? 1 : 0;
    localparam int PER = 2 + GAP;

    pcma_coe_loader_if #(.COE_WIDTH(COE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.start     = start;
    assign bus.preset_en = preset_en;

    pcma_coe_loader #(
      .COE_WIDTH (COE_WIDTH),
      .EQ_LEN    (EQ_LEN),
      .ADDR_WIDTH(ADDR_WIDTH),
      .STROBE_GAP(GAP)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
    );

    ev_t                  q[$];
    int                   eq[$];
    logic [COE_WIDTH-1:0] m_bank [EQ_LEN];
    int                   m_busy_from = 0;
    int                   m_done_cyc = -1;
    logic [COE_WIDTH-1:0] m_idle_init = '0;

    // Reference model: on each accepted start, schedule every output event.
    always @(posedge clk) begin
      bit idle;
      int p;
      int done_at;
      if (reset) begin
        while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
        while (eq.size() > 0 && eq[eq.size()-1] > cyc) void'(eq.pop_back());
        for (int i = 0; i < EQ_LEN; i++) m_bank[i] <= '0;
        if (m_done_cyc > cyc) m_done_cyc <= cyc;
        m_idle_init <= '0;
      end else begin
        idle = (cyc > m_done_cyc);
        if (wr_en) begin
          if (int'(wr_addr) < EQ_LEN && idle && !start) m_bank[wr_addr] <= wr_data;
          else eq.push_back(cyc + 1);
        end
        if (start && idle) begin
          p = preset_en ? 1 : 0;
          done_at = cyc + p + EQ_LEN * PER + 1;
          if (p == 1) q.push_back('{K_PRE, cyc + 1, COE_WIDTH'(0)});
          for (int k = 0; k < EQ_LEN; k++)
            q.push_back('{K_LOAD, cyc + p + 2 + k * PER, m_bank[k]});
          q.push_back('{K_DONE, done_at, COE_WIDTH'(0)});
          m_busy_from <= cyc + 1;
          m_done_cyc  <= done_at;
          m_idle_init <= m_bank[EQ_LEN-1];
        end
      end
    end

    task automatic take(input int kind, input logic [COE_WIDTH-1:0] val);
      bit  ok;
      ev_t e;
      ok = (q.size() > 0) && (q[0].cyc == cyc) && (q[0].kind == kind);
      chk(ok, $sformatf("g%0d event_kind%0d_timing", g, kind), cyc,
          (q.size() > 0) ? q[0].cyc : -1);
      if (ok) begin
        e = q.pop_front();
        if (kind == K_LOAD)
          chk(val == e.val, $sformatf("g%0d tap_value", g), $signed(val), $signed(e.val));
      end
    endtask

    always @(negedge clk) begin
      bit exp_busy;
      bit ok;
      if (mon_en) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          chk(1'b0, $sformatf("g%0d missed_event_kind%0d", g, q[0].kind), -1, q[0].cyc);
          void'(q.pop_front());
        end
        while (eq.size() > 0 && eq[0] < cyc) begin
          chk(1'b0, $sformatf("g%0d missed_wr_err", g), -1, eq[0]);
          void'(eq.pop_front());
        end
        if (bus.o_preset_coe) take(K_PRE, bus.o_init_coe);
        if (bus.o_load_coe)   take(K_LOAD, bus.o_init_coe);
        if (bus.o_done)       take(K_DONE, bus.o_init_coe);
        if (bus.o_wr_err) begin
          ok = (eq.size() > 0) && (eq[0] == cyc);
          chk(ok, $sformatf("g%0d wr_err_timing", g), cyc, (eq.size() > 0) ? eq[0] : -1);
          if (ok) void'(eq.pop_front());
        end
        exp_busy = (cyc >= m_busy_from) && (cyc <= m_done_cyc);
        chk(bus.o_busy == exp_busy, $sformatf("g%0d busy", g), bus.o_busy, exp_busy);
        if (!exp_busy)
          chk(bus.o_init_coe == m_idle_init, $sformatf("g%0d idle_init_coe", g),
              $signed(bus.o_init_coe), $signed(m_idle_init));
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_write(input int addr, input logic [COE_WIDTH-1:0] data);
    wr_en   = 1'b1;
    wr_addr = ADDR_WIDTH'(addr);
    wr_data = data;
    tick(1);
    wr_en   = 1'b0;
  endtask

  initial begin
    tick(3);
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < EQ_LEN; k++) host_write(k, COE_WIDTH'(taps[k]));
    host_write(19, COE_WIDTH'(12345));
    host_write(31, COE_WIDTH'(777));
    tick(2);

    // Preset sequence with an ignored restart and a rejected busy write.
    start = 1'b1; preset_en = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    host_write(3, COE_WIDTH'(999));
    tick(60);

    start = 1'b1; preset_en = 1'b0;
    tick(1);
    start = 1'b0;
    tick(70);

    // Abort by reset partway through, then stream the cleared bank.
    start = 1'b1; preset_en = 1'b1;
    tick(1);
    start = 1'b0;
    tick(19);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    start = 1'b1; preset_en = 1'b0;
    tick(1);
    start = 1'b0;
    tick(70);

    for (int i = 0; i < 400; i++) begin
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_addr   = ADDR_WIDTH'($urandom_range(0, 22));
      wr_data   = COE_WIDTH'($urandom);
      start     = ($urandom_range(0, 19) == 0);
      preset_en = $urandom_range(0, 1) == 1;
      tick(1);
    end
    wr_en = 1'b0;
    start = 1'b0;
    tick(70);

    start = 1'b1; preset_en = 1'b1;
    tick(200);
    start = 1'b0;
    tick(100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
